pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Acts on hazard and memory-wait conditions; the hazard detector only raises them. Sits beside the
//  ID stage of the 5-stage pipeline and drives freeze/flush/bubble controls for the PC, IF/ID and ID/EX
//  registers, plus a global freeze while the SRAM controller stalls a MEM-stage access.
//  Owns a small FSM (RUN/MEM_WAIT/TIMEOUT), a memory-wait watchdog and optional stall counters.
// PARAMETERS
//  TIMEOUT_CYC  256  MEM_WAIT cycles before declaring a lock-up (range 2..65535)
//  CNT_W        32   width of performance counters
// PORTS
//  clk              in   1      rising-edge clock, single domain
//  rst_n            in   1      asynchronous, active-low reset
//  hazard_detected  in   1      from hazard detection unit (ID-stage RAW hazard)
//  branch_taken     in   1      EXE-stage taken branch; younger IF/ID instr must die
//  mem_access       in   1      MEM stage holds a load/store this cycle
//  mem_ready        in   1      SRAM controller: access completes this cycle
//  freeze_pc        out  1      hold PC
//  freeze_if_id     out  1      hold IF/ID register
//  bubble_id_ex     out  1      load NOP into ID/EX
//  flush_if_id      out  1      clear IF/ID register
//  freeze_pipe      out  1      hold ID/EX, EXE/MEM, MEM/WB (memory wait)
//  timeout_err      out  1      sticky, registered lock-up flag
//  stall_cycles     out  CNT_W  cycles with freeze_pc=1 (STALL_PERF_EN)
//  flush_count      out  CNT_W  number of flush_if_id pulses (STALL_PERF_EN)
// BEHAVIOUR
//  - Control outputs are Mealy: f(state, inputs), valid in the same cycle. While rst_n=0 all outputs are 0,
//    state=RUN, wait_cnt=0, counters=0.
//  - Priority each cycle: memory wait > branch_taken > hazard_detected.
//  - RUN: mem_access & ~mem_ready -> freeze_pipe=freeze_pc=freeze_if_id=1, bubble=flush=0; next MEM_WAIT, wait_cnt=1.
//    else branch_taken -> flush_if_id=1, bubble_id_ex=1, freeze_*=0 (hazard ignored: its instr is killed).
//    else hazard_detected -> freeze_pc=freeze_if_id=1, bubble_id_ex=1, flush=0.
//    else all controls 0.
//  - MEM_WAIT: mem_ready=0 -> freeze_pipe=freeze_pc=freeze_if_id=1, bubble=flush=0; wait_cnt++.
//    mem_ready=1 -> same cycle resolves as RUN without the memory term (branch/hazard evaluated);
//    next RUN, wait_cnt=0.
//    wait_cnt==TIMEOUT_CYC with mem_ready=0 -> next TIMEOUT.
//  - TIMEOUT: terminal until reset; timeout_err=1 (set on entry edge), freeze_pipe=freeze_pc=freeze_if_id=1, others 0.
//  - branch_taken/hazard_detected during a freeze are not latched; the frozen pipeline re-presents them.
//  - mem_ready with mem_access=0 is ignored in RUN.
//  - A reset asserted mid-wait returns to RUN immediately (async); no partial state survives.
//  - wait_cnt is 16 bits and never wraps (TIMEOUT is reached first).
// CONFIGURATION
//  STALL_PERF_EN defined: stall_cycles += 1 each cycle freeze_pc=1; flush_count += 1 each cycle flush_if_id=1;
//    both saturate at all-ones and do not advance in TIMEOUT.
//  STALL_PERF_EN undefined: no counter registers; stall_cycles and flush_count tied to 0; ports kept.
// TESTING
//  1 reset: rst_n=0 with hazard_detected=1 -> all outputs 0; release -> freeze_pc=1, bubble_id_ex=1 same cycle.
//  2 hazard 2 cycles, then 0 -> freeze_pc/freeze_if_id/bubble high exactly 2 cycles; stall_cycles=2 (perf on).
//  3 branch_taken=1 & hazard_detected=1 -> flush_if_id=1, bubble_id_ex=1, freeze_pc=0; flush_count=1.
//  4 mem_access=1, mem_ready low 3 cycles then high with hazard=1 -> freeze_pipe high 3 cycles;
//    4th cycle freeze_pipe=0, hazard stall applied; state RUN next.
//  5 TIMEOUT_CYC=4, mem_ready held 0 -> after 4 MEM_WAIT cycles timeout_err=1 sticky;
//    mem_ready=1 has no effect; rst_n pulse clears.
//  6 STALL_PERF_EN undefined, scenario 2 -> stall_cycles=0, control behaviour identical.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller beside the ID stage: RUN/MEM_WAIT/TIMEOUT FSM with memory-wait watchdog.
// Optional stall/flush performance counters are built when STALL_PERF_EN is defined.
module pipeline_stall_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             freeze_pipe,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_e;

    localparam logic [15:0] TO_CNT = 16'(TIMEOUT_CYC);

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q;

    logic fpc_c, fif_c, bub_c, flu_c, fpp_c;
    logic run_freeze, run_bubble, run_flush;

    // Branch/hazard resolution shared by RUN and the MEM_WAIT completion cycle.
    always_comb begin
        run_freeze = 1'b0;
        run_bubble = 1'b0;
        run_flush  = 1'b0;
        if (branch_taken) begin
            run_flush  = 1'b1;
            run_bubble = 1'b1;
        end else if (hazard_detected) begin
            run_freeze = 1'b1;
            run_bubble = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        fpc_c      = 1'b0;
        fif_c      = 1'b0;
        bub_c      = 1'b0;
        flu_c      = 1'b0;
        fpp_c      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_access && !mem_ready) begin
                    fpc_c      = 1'b1;
                    fif_c      = 1'b1;
                    fpp_c      = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 16'd1;
                end else begin
                    fpc_c = run_freeze;
                    fif_c = run_freeze;
                    bub_c = run_bubble;
                    flu_c = run_flush;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    fpc_c = 1'b1;
                    fif_c = 1'b1;
                    fpp_c = 1'b1;
                    if (wait_cnt_q == TO_CNT) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end else begin
                    fpc_c      = run_freeze;
                    fif_c      = run_freeze;
                    bub_c      = run_bubble;
                    flu_c      = run_flush;
                    state_d    = ST_RUN;
                    wait_cnt_d = 16'd0;
                end
            end
            ST_TIMEOUT: begin
                fpc_c = 1'b1;
                fif_c = 1'b1;
                fpp_c = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_q | (state_d == ST_TIMEOUT);
        end
    end

    // Mealy outputs are forced low while reset is held.
    assign freeze_pc    = rst_n & fpc_c;
    assign freeze_if_id = rst_n & fif_c;
    assign bubble_id_ex = rst_n & bub_c;
    assign flush_if_id  = rst_n & flu_c;
    assign freeze_pipe  = rst_n & fpp_c;
    assign timeout_err  = timeout_err_q;
    assign dbg_state    = state_q;

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (state_q != ST_TIMEOUT) begin
            if (fpc_c && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (flu_c && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (TIMEOUT_CYC=4); counter expectations follow STALL_PERF_EN.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 32;
`ifdef STALL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             hazard_detected, branch_taken, mem_access, mem_ready;
    logic             freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_pipe, timeout_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [1:0]       dbg_state;
    logic [5:0]       ctrl;

    int checks = 0;
    int errors = 0;

    pipeline_stall_ctrl #(.TIMEOUT_CYC(4), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_access      (mem_access),
        .mem_ready       (mem_ready),
        .freeze_pc       (freeze_pc),
        .freeze_if_id    (freeze_if_id),
        .bubble_id_ex    (bubble_id_ex),
        .flush_if_id     (flush_if_id),
        .freeze_pipe     (freeze_pipe),
        .timeout_err     (timeout_err),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .dbg_state       (dbg_state)
    );

    // ctrl = {freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_pipe, timeout_err}
    assign ctrl = {freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_pipe, timeout_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic ma, input logic mr, input logic br, input logic hz);
        @(negedge clk);
        mem_access      = ma;
        mem_ready       = mr;
        branch_taken    = br;
        hazard_detected = hz;
        #1;
    endtask

    function automatic logic [31:0] perf(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    initial begin
        rst_n = 1'b0; hazard_detected = 1'b1; branch_taken = 1'b0;
        mem_access = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctrl", 32'(ctrl), 32'h00);
        check("reset_state", 32'(dbg_state), 32'd0);
        check("reset_stall", stall_cycles, 32'd0);
        check("reset_flush", flush_count, 32'd0);

        // release with hazard held: stall applies in the same cycle
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_hazard", 32'(ctrl), 32'b111000);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("hazard_2", 32'(ctrl), 32'b111000);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("hazard_off", 32'(ctrl), 32'b000000);
        check("stall_after_hz", stall_cycles, perf(2));

        // branch overrides hazard
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("branch_hz", 32'(ctrl), 32'b001100);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_after_br", 32'(ctrl), 32'b000000);
        check("flush_cnt", flush_count, perf(1));
        check("stall_kept", stall_cycles, perf(2));

        // memory wait 3 cycles, then completion with hazard
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("mw_1", 32'(ctrl), 32'b110010);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("mw_2_branch", 32'(ctrl), 32'b110010);
        check("mw_state", 32'(dbg_state), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        check("mw_3_hazard", 32'(ctrl), 32'b110010);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("mw_done_hz", 32'(ctrl), 32'b111000);
        check("mw_done_state", 32'(dbg_state), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("ready_no_access", 32'(ctrl), 32'b000000);
        check("run_state", 32'(dbg_state), 32'd0);
        check("stall_after_mw", stall_cycles, perf(6));
        check("flush_after_mw", flush_count, perf(1));

        // watchdog: RUN entry + 4 MEM_WAIT cycles, then TIMEOUT
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("to_entry", 32'(ctrl), 32'b110010);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("to_wait_%0d", i), 32'(ctrl), 32'b110010);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("to_err", 32'(ctrl), 32'b110011);
        check("to_state", 32'(dbg_state), 32'd2);
        check("to_stall", stall_cycles, perf(11));
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("to_sticky", 32'(ctrl), 32'b110011);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("to_sticky2", 32'(ctrl), 32'b110011);
        check("to_stall_frozen", stall_cycles, perf(11));
        check("to_flush_frozen", flush_count, perf(1));

        // reset pulse clears TIMEOUT
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("to_rst_ctrl", 32'(ctrl), 32'h00);
        check("to_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_access = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; hazard_detected = 1'b0;
        #1;
        check("post_rst_ctrl", 32'(ctrl), 32'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_state", 32'(dbg_state), 32'd0);
        check("post_rst_stall", stall_cycles, 32'd0);

        // reset mid-wait returns to RUN with no leftover state
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_1", 32'(ctrl), 32'b110010);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_state", 32'(dbg_state), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 32'(ctrl), 32'h00);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_access = 1'b0;
        #1;
        check("mid_rel_ctrl", 32'(ctrl), 32'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_fresh_wait", 32'(ctrl), 32'b110010);
        check("mid_stall", stall_cycles, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("mid_fresh_done", 32'(ctrl), 32'b000000);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_fresh_state", 32'(dbg_state), 32'd0);
        check("mid_fresh_stall", stall_cycles, perf(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
